// File: rtl/bus_arb_mux.sv
// Purpose: arbitrate NUM_MASTERS bus masters onto NUM_SLAVES address-decoded slaves, one transaction in flight.
// Latency: grant is combinational in the request cycle; response is forwarded combinationally from the slave.
// Backpressure: a master whose target holds s_gnt low stays locked in ADDR; other masters wait in IDLE.
//
// Ports:
//   Clk, Rst_n             clock, asynchronous active-low reset
//   m_req/m_we/m_addr/m_wdata/m_be   per-master request side (flattened, master 0 in the LSBs)
//   m_gnt/m_rvalid/m_err, m_rdata    per-master grant/response, shared read data
//   s_req, s_addr/s_wdata/s_be/s_we  per-slave request, shared address/data/control
//   s_gnt/s_rvalid/s_err, s_rdata    per-slave grant/response (flattened, slave 0 in the LSBs)
//   slv_dead                         sticky per-slave timeout flags, cleared by a late s_rvalid
module bus_arb_mux #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 5,
  parameter logic [NUM_SLAVES-1:0][31:0] SLV_BASE = {32'h4000_0000, 32'h3000_0000, 32'h2000_0000,
                                                     32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES-1:0][31:0] SLV_MASK = {NUM_SLAVES{32'hF000_0000}},
  parameter int ARB_MODE    = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic [NUM_MASTERS-1:0]   m_req,
  input  logic [NUM_MASTERS-1:0]   m_we,
  input  logic [32*NUM_MASTERS-1:0] m_addr,
  input  logic [32*NUM_MASTERS-1:0] m_wdata,
  input  logic [4*NUM_MASTERS-1:0] m_be,
  output logic [NUM_MASTERS-1:0]   m_gnt,
  output logic [NUM_MASTERS-1:0]   m_rvalid,
  output logic [NUM_MASTERS-1:0]   m_err,
  output logic [31:0]              m_rdata,
  output logic [NUM_SLAVES-1:0]    s_req,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_be,
  output logic                     s_we,
  input  logic [NUM_SLAVES-1:0]    s_gnt,
  input  logic [NUM_SLAVES-1:0]    s_rvalid,
  input  logic [NUM_SLAVES-1:0]    s_err,
  input  logic [32*NUM_SLAVES-1:0] s_rdata,
  output logic [NUM_SLAVES-1:0]    slv_dead
);

  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, RESP, ERR} state_t;

  state_t                state_q, state_d;
  logic [MW-1:0]         win_q, win_d;
  logic [MW-1:0]         last_q, last_d;
  logic [SW-1:0]         slv_q, slv_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0] dead_q, dead_d;

  logic [MW-1:0] arb_idx, act_idx;
  logic          arb_found, in_addr, hit, timeout;
  logic [SW-1:0] hit_idx;
  logic [31:0]   cur_addr;

  logic [31:0] maddr_a [NUM_MASTERS];
  logic [31:0] mwdata_a[NUM_MASTERS];
  logic [3:0]  mbe_a   [NUM_MASTERS];
  logic [31:0] srdata_a[NUM_SLAVES];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_mst
    assign maddr_a[g]  = m_addr[32*g +: 32];
    assign mwdata_a[g] = m_wdata[32*g +: 32];
    assign mbe_a[g]    = m_be[4*g +: 4];
  end
  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slv
    assign srdata_a[g] = s_rdata[32*g +: 32];
  end

  // Arbiter: only consulted in IDLE; the chosen index is then locked in win_q.
  always_comb begin
    int j;
    j         = 0;
    arb_idx   = '0;
    arb_found = 1'b0;
    if (ARB_MODE == 1) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!arb_found && m_req[i]) begin
          arb_idx   = MW'(i);
          arb_found = 1'b1;
        end
      end
    end else begin
      for (int k = 1; k <= NUM_MASTERS; k++) begin
        j = (int'(last_q) + k) % NUM_MASTERS;
        if (!arb_found && m_req[j]) begin
          arb_idx   = MW'(j);
          arb_found = 1'b1;
        end
      end
    end
  end

  // IDLE with a request behaves as ADDR in the same cycle, using the fresh winner.
  assign act_idx  = (state_q == IDLE) ? arb_idx : win_q;
  assign in_addr  = (state_q == ADDR) || ((state_q == IDLE) && arb_found);
  assign cur_addr = maddr_a[act_idx];

  // Address decode; dead slaves are invisible so their range decodes as an error.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!hit && ((cur_addr & SLV_MASK[i]) == SLV_BASE[i]) && !dead_q[i]) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

  // A real response in the final cycle wins over the timeout.
  assign timeout = (state_q == RESP) && !s_rvalid[slv_q] && (cnt_q == 16'(TIMEOUT));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      last_q  <= MW'(NUM_MASTERS - 1);
      slv_q   <= '0;
      cnt_q   <= '0;
      dead_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      slv_q   <= slv_d;
      cnt_q   <= cnt_d;
      dead_q  <= dead_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    slv_d   = slv_q;
    cnt_d   = cnt_q;
    // Any response from a dead slave revives it; it is never forwarded.
    dead_d  = dead_q & ~s_rvalid;
    case (state_q)
      IDLE, ADDR: begin
        if (in_addr) begin
          win_d   = act_idx;
          state_d = ADDR;
          if (!hit) begin
            state_d = ERR;
            last_d  = act_idx;
          end else if (s_gnt[hit_idx]) begin
            state_d = RESP;
            slv_d   = hit_idx;
            cnt_d   = '0;
            last_d  = act_idx;
          end
        end
      end
      RESP: begin
        if (s_rvalid[slv_q]) begin
          state_d = IDLE;
        end else if (timeout) begin
          dead_d[slv_q] = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are gated by Rst_n so an asserted reset silences the bus immediately.
  always_comb begin
    m_gnt    = '0;
    m_rvalid = '0;
    m_err    = '0;
    m_rdata  = '0;
    s_req    = '0;
    s_addr   = cur_addr;
    s_wdata  = mwdata_a[act_idx];
    s_be     = mbe_a[act_idx];
    s_we     = m_we[act_idx];
    if (Rst_n) begin
      case (state_q)
        IDLE, ADDR: begin
          if (in_addr) begin
            if (hit) begin
              s_req[hit_idx] = 1'b1;
              m_gnt[act_idx] = s_gnt[hit_idx];
            end else begin
              m_gnt[act_idx] = 1'b1;
            end
          end
        end
        RESP: begin
          if (timeout) begin
            m_rvalid[win_q] = 1'b1;
            m_err[win_q]    = 1'b1;
          end else begin
            m_rvalid[win_q] = s_rvalid[slv_q];
            m_err[win_q]    = s_err[slv_q];
            m_rdata         = srdata_a[slv_q];
          end
        end
        ERR: begin
          m_rvalid[win_q] = 1'b1;
          m_err[win_q]    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign slv_dead = dead_q;

endmodule

// File: tb/tb_bus_arb_mux.sv
module tb_bus_arb_mux;

  logic         Clk, Rst_n;
  logic [1:0]   m_req, m_we;
  logic [63:0]  m_addr, m_wdata;
  logic [7:0]   m_be;
  logic [4:0]   s_gnt, s_rvalid, s_err;
  logic [159:0] s_rdata;

  logic [1:0]  m_gnt, m_rvalid, m_err;
  logic [31:0] m_rdata, s_addr, s_wdata;
  logic [4:0]  s_req, slv_dead;
  logic [3:0]  s_be;
  logic        s_we;

  logic [1:0]  fp_m_gnt, fp_m_rvalid, fp_m_err;
  logic [31:0] fp_m_rdata, fp_s_addr, fp_s_wdata;
  logic [4:0]  fp_s_req, fp_slv_dead;
  logic [3:0]  fp_s_be;
  logic        fp_s_we;

  int checks   = 0;
  int failures = 0;

  logic       proto_en = 1'b0;
  logic [1:0] pend     = 2'b00;

  bus_arb_mux #(.ARB_MODE(0), .TIMEOUT(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_err(m_err), .m_rdata(m_rdata),
    .s_req(s_req), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be), .s_we(s_we),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_err(s_err), .s_rdata(s_rdata),
    .slv_dead(slv_dead)
  );

  bus_arb_mux #(.ARB_MODE(1), .TIMEOUT(4)) dut_fp (
    .Clk(Clk), .Rst_n(Rst_n),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_gnt(fp_m_gnt), .m_rvalid(fp_m_rvalid), .m_err(fp_m_err), .m_rdata(fp_m_rdata),
    .s_req(fp_s_req), .s_addr(fp_s_addr), .s_wdata(fp_s_wdata), .s_be(fp_s_be), .s_we(fp_s_we),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_err(s_err), .s_rdata(s_rdata),
    .slv_dead(fp_slv_dead)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // A master that requested and was not granted must keep requesting.
  always @(posedge Clk) begin
    for (int k = 0; k < 2; k++) begin
      assert (!(proto_en && pend[k] && !m_req[k]))
        else $error("FAIL proto_hold master=%0d dropped m_req before m_gnt", k);
    end
    pend <= (proto_en && Rst_n) ? (m_req & ~m_gnt) : 2'b00;
  end

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_m(input int idx, input logic req, input logic we, input logic [31:0] addr);
    m_req[idx]          = req;
    m_we[idx]           = we;
    m_addr[32*idx +: 32] = addr;
  endtask

  initial begin
    Rst_n    = 1'b0;
    m_req    = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_be = '0;
    s_gnt    = '0; s_rvalid = '0; s_err = '0; s_rdata = '0;

    // Reset state, including a live request that must be masked.
    #2;
    set_m(0, 1'b1, 1'b0, 32'h1000_0004);
    s_gnt[1] = 1'b1;
    #1;
    chk("rst_gnt",    {30'd0, m_gnt}, 32'd0);
    chk("rst_sreq",   {27'd0, s_req}, 32'd0);
    chk("rst_rvalid", {30'd0, m_rvalid | m_err}, 32'd0);
    chk("rst_rdata",  m_rdata, 32'd0);
    chk("rst_dead",   {27'd0, slv_dead}, 32'd0);
    tick();
    m_req = '0; s_gnt = '0;
    tick();
    Rst_n = 1'b1;

    // Simple read to slave1, grant in cycle 0, data in cycle 2.
    tick();
    set_m(0, 1'b1, 1'b0, 32'h1000_0004);
    s_gnt[1] = 1'b1;
    #1;
    chk("rd_gnt",   {30'd0, m_gnt}, 32'd1);
    chk("rd_sreq",  {27'd0, s_req}, 32'b00010);
    chk("rd_saddr", s_addr, 32'h1000_0004);
    chk("rd_swe",   {31'd0, s_we}, 32'd0);
    tick();
    m_req = '0; s_gnt = '0;
    #1;
    chk("rd_wait_rvalid", {30'd0, m_rvalid}, 32'd0);
    tick();
    s_rvalid[1] = 1'b1; s_rdata[63:32] = 32'hDEAD_BEEF;
    #1;
    chk("rd_rvalid", {30'd0, m_rvalid}, 32'd1);
    chk("rd_rdata",  m_rdata, 32'hDEAD_BEEF);
    chk("rd_err",    {30'd0, m_err}, 32'd0);
    tick();
    s_rvalid = '0;

    // Unmapped write by M1 gives an immediate grant then a one-cycle error.
    set_m(1, 1'b1, 1'b1, 32'h9000_0000);
    #1;
    chk("um_gnt",  {30'd0, m_gnt}, 32'b10);
    chk("um_sreq", {27'd0, s_req}, 32'd0);
    tick();
    m_req = '0; m_we = '0;
    #1;
    chk("um_rvalid", {30'd0, m_rvalid}, 32'b10);
    chk("um_err",    {30'd0, m_err}, 32'b10);
    chk("um_rdata",  m_rdata, 32'd0);
    tick();
    #1;
    chk("um_done", {30'd0, m_rvalid}, 32'd0);

    // Both masters request continuously: RR alternates, fixed priority sticks to M0.
    tick();
    set_m(0, 1'b1, 1'b0, 32'h0000_0010);
    set_m(1, 1'b1, 1'b0, 32'h0000_0020);
    s_gnt[0] = 1'b1; s_rvalid[0] = 1'b1; s_rdata[31:0] = 32'h0000_1234;
    for (int g = 0; g < 4; g++) begin
      logic [1:0] exp_g;
      exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      chk("rr_gnt", {30'd0, m_gnt}, {30'd0, exp_g});
      chk("fp_gnt", {30'd0, fp_m_gnt}, 32'b01);
      tick();
      #1;
      chk("rr_rvalid", {30'd0, m_rvalid}, {30'd0, exp_g});
      chk("rr_rdata",  m_rdata, 32'h0000_1234);
      tick();
    end
    m_req = '0; s_gnt = '0; s_rvalid = '0; s_rdata = '0;

    // Write to slave3 with wait states; winner stays locked; slave error forwarded.
    proto_en = 1'b1;
    tick();
    set_m(0, 1'b1, 1'b1, 32'h3000_0000);
    m_wdata[31:0] = 32'h1234_5678; m_be[3:0] = 4'b0011;
    #1;
    chk("ws_sreq0", {27'd0, s_req}, 32'b01000);
    chk("ws_gnt0",  {30'd0, m_gnt}, 32'd0);
    chk("ws_wdata", s_wdata, 32'h1234_5678);
    chk("ws_be",    {28'd0, s_be}, 32'h3);
    chk("ws_we",    {31'd0, s_we}, 32'd1);
    tick();
    set_m(1, 1'b1, 1'b0, 32'h1000_0000);
    #1;
    chk("ws_lock_sreq",  {27'd0, s_req}, 32'b01000);
    chk("ws_lock_addr",  s_addr, 32'h3000_0000);
    chk("ws_lock_gnt",   {30'd0, m_gnt}, 32'd0);
    tick();
    s_gnt[3] = 1'b1;
    #1;
    chk("ws_gnt", {30'd0, m_gnt}, 32'b01);
    tick();
    m_req[0] = 1'b0; m_we = '0; s_gnt = '0;
    s_rvalid[3] = 1'b1; s_err[3] = 1'b1; s_rdata[127:96] = 32'hBAD0_0BAD;
    #1;
    chk("serr_rvalid", {30'd0, m_rvalid}, 32'b01);
    chk("serr_err",    {30'd0, m_err}, 32'b01);
    chk("serr_rdata",  m_rdata, 32'hBAD0_0BAD);
    tick();
    s_rvalid = '0; s_err = '0; s_gnt[1] = 1'b1;
    #1;
    chk("serr_dead", {27'd0, slv_dead}, 32'd0);
    chk("b2b_sreq",  {27'd0, s_req}, 32'b00010);
    chk("b2b_gnt",   {30'd0, m_gnt}, 32'b10);
    tick();
    m_req = '0; s_gnt = '0;
    s_rvalid[1] = 1'b1; s_rdata[63:32] = 32'h5555_AAAA;
    #1;
    chk("b2b_rvalid", {30'd0, m_rvalid}, 32'b10);
    chk("b2b_rdata",  m_rdata, 32'h5555_AAAA);
    tick();
    s_rvalid = '0;
    proto_en = 1'b0;

    // Timeout on slave2, then decode error on the dead slave, then late revival.
    set_m(0, 1'b1, 1'b0, 32'h2000_0000);
    s_gnt[2] = 1'b1; s_rdata[95:64] = 32'hFFFF_FFFF;
    #1;
    chk("to_gnt",  {30'd0, m_gnt}, 32'b01);
    chk("to_sreq", {27'd0, s_req}, 32'b00100);
    tick();
    m_req = '0; s_gnt = '0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("to_wait", {30'd0, m_rvalid}, 32'd0);
      tick();
    end
    #1;
    chk("to_rvalid", {30'd0, m_rvalid}, 32'b01);
    chk("to_err",    {30'd0, m_err}, 32'b01);
    chk("to_rdata",  m_rdata, 32'd0);
    tick();
    set_m(0, 1'b1, 1'b0, 32'h2000_0000);
    s_gnt[2] = 1'b1;
    #1;
    chk("to_dead",     {27'd0, slv_dead}, 32'b00100);
    chk("dead_sreq",   {27'd0, s_req}, 32'd0);
    chk("dead_gnt",    {30'd0, m_gnt}, 32'b01);
    tick();
    m_req = '0; s_gnt = '0;
    #1;
    chk("dead_rvalid", {30'd0, m_rvalid}, 32'b01);
    chk("dead_err",    {30'd0, m_err}, 32'b01);
    tick();
    s_rvalid[2] = 1'b1;
    #1;
    chk("late_rvalid", {30'd0, m_rvalid}, 32'd0);
    tick();
    s_rvalid = '0;
    #1;
    chk("late_revive", {27'd0, slv_dead}, 32'd0);

    // Reset while in RESP: outputs drop at once, arbitration restarts at M0.
    tick();
    set_m(0, 1'b1, 1'b0, 32'h1000_0008);
    s_gnt[1] = 1'b1;
    #1;
    chk("rr_pre_gnt", {30'd0, m_gnt}, 32'b01);
    tick();
    m_req = '0; s_gnt = '0;
    s_rvalid[1] = 1'b1; s_rdata[63:32] = 32'h0BAD_F00D;
    Rst_n = 1'b0;
    #1;
    chk("mrst_rvalid", {30'd0, m_rvalid}, 32'd0);
    chk("mrst_rdata",  m_rdata, 32'd0);
    tick();
    s_rvalid = '0;
    Rst_n = 1'b1;
    tick();
    set_m(0, 1'b1, 1'b0, 32'h0000_0000);
    set_m(1, 1'b1, 1'b0, 32'h0000_0004);
    s_gnt[0] = 1'b1;
    #1;
    chk("post_rst_gnt", {30'd0, m_gnt}, 32'b01);
    tick();
    m_req = '0; s_gnt = '0;
    s_rvalid[0] = 1'b1; s_rdata[31:0] = 32'hCAFE_F00D;
    #1;
    chk("post_rst_rvalid", {30'd0, m_rvalid}, 32'b01);
    chk("post_rst_rdata",  m_rdata, 32'hCAFE_F00D);
    tick();
    s_rvalid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
